irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Parametrised interrupt controller that replaces the fixed three-key/one-timer controller in the core top. Accepts `NUM_SRC` asynchronous interrupt lines, each either edge- or level-sensitive, synchronises and latches them, and applies per-source enables and the global `mstatus.MIE`. It arbitrates by fixed priority and drives the trap entry/exit handshake to IF and the CSR file. It sits beside `CSRFile`; its `int_index` feeds `mcause` generation.

## Interface

Parameters:

- `NUM_SRC`, 8: number of interrupt sources, 1..16.
- `IDX_W`, 4: width of `int_index`; must satisfy 2^IDX_W ≥ NUM_SRC.
- `SYNC_STAGES`, 2: synchroniser flops per source, 2..3.
- `EDGE_MASK`, {NUM_SRC{1'b1}}: bit i = 1 makes source i rising-edge; 0 makes it level-high.

Ports:

- `clk` in 1: core clock.
- `rst` in 1: reset, asynchronous, active-high.
- `irq_src` in NUM_SRC: raw asynchronous interrupt lines.
- `irq_enable` in NUM_SRC: per-source enable (mie-style), synchronous to `clk`.
- `int_mstatus_mie` in 1: global interrupt enable from the CSR file.
- `core_ready` in 1: core can take a trap this cycle (no outstanding data-bus transfer, no divide in flight).
- `mret_en` in 1: one-cycle pulse from ID when `mret` is decoded.
- `trap_entry_en` out 1: one-cycle pulse; IF redirects to the trap vector.
- `trap_exit_en` out 1: one-cycle pulse; IF restores `mepc`.
- `int_index` out IDX_W: index of the serviced source.
- `int_active` out 1: a trap is being serviced.
- `irq_pending` out NUM_SRC: pending vector, readable as a `mip` image.

Reset values: every output is 0; all synchroniser, edge and pending flops are 0; FSM is IDLE.

## Operation

- Each source passes through `SYNC_STAGES` flops.
  - Edge sources also have a one-flop delay stage, and `rise_i = sync_i & ~dly_i`.
- Pending logic:
  - Edge source: `pend_i` is set on `rise_i` and cleared in the entry cycle when i is the winner. If set and clear hit the same cycle, set wins (the source stays pending).
  - Level source: `pend_i = sync_i`, not latched. It is never cleared by the controller.
- Request: `req = pend & irq_enable`. The winner is the lowest set index of `req`.
- FSM states are IDLE and ACTIVE.
  - IDLE → ACTIVE when `int_mstatus_mie & |req & core_ready`. In that cycle:
    - next-cycle `trap_entry_en` = 1;
    - `int_index` ← winner;
    - `int_active` ← 1.
  - ACTIVE → IDLE on `mret_en`. Next-cycle `trap_exit_en` = 1 and `int_active` ← 0.
  - `int_index` holds its value until the next entry.
- No nesting:
  - requests arriving during ACTIVE only accumulate in `pend`;
  - `mret_en` in IDLE is ignored;
  - `irq_enable`/`mie` changes during ACTIVE do not abort the trap.
- The same cycle that ACTIVE → IDLE may not start a new entry. Earliest re-entry is one cycle after `trap_exit_en`.
- An asynchronous `rst` in any state returns the block to reset values immediately and discards pending edges.

## Timing

- Edge source rising at cycle 0, with `core_ready = 1` and enables set:
  - `irq_pending` bit visible at cycle SYNC_STAGES+1;
  - `trap_entry_en` high at cycle SYNC_STAGES+2 (4 with default parameters).
- Level source: one cycle less, i.e. `trap_entry_en` at cycle SYNC_STAGES+1.
- `core_ready` low stalls entry indefinitely; pending state is held.
- Every output is registered; there is no combinational path from any input to any output.
- `mret_en` at cycle n gives `trap_exit_en` at n+1.

## Structure

- Shared package `irq_pkg` holds:
  - the FSM state encoding (IDLE=1'b0, ACTIVE=1'b1);
  - the default `NUM_SRC`/`IDX_W`;
  - cause-code base constants used by `CSRFile`.
- One sub-module, `irq_sync`, instantiated NUM_SRC times by generate loop:
  - parameters `SYNC_STAGES` and `EDGE`;
  - output is either `rise` or the synced level.
- The priority encoder and FSM live in the top of `irq_arbiter`.

## Test plan

- Edge source 3 pulses once, `irq_enable=8'h08`, `mie=1`, `core_ready=1` → `trap_entry_en` at cycle 4, `int_index=3`, `irq_pending[3]` clears in the entry cycle; `mret_en` → `trap_exit_en` next cycle, `int_active=0`.
- Sources 5 and 2 rise in the same cycle → entry with `int_index=2`; after `mret`, a second entry with `int_index=5` one cycle after `trap_exit_en`.
- `mie=0` with source 1 pending for 20 cycles → no entry, `irq_pending[1]=1`; raise `mie` → entry on the next eligible cycle with `int_index=1`.
- `core_ready=0` for 10 cycles after source 0 is pending → no pulse; `core_ready=1` → `trap_entry_en` the following cycle.
- Level source (EDGE_MASK bit 4 = 0): hold high through service → re-entry after `mret`; drop low before entry → no trap.
- Assert `rst` during ACTIVE with source 6 pending → all outputs 0 immediately, no entry after release until a new edge arrives; `mret_en` in IDLE → no `trap_exit_en`.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the parametrised interrupt arbiter.
// Also holds the cause-code constants that CSRFile uses to build mcause.
package irq_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } irq_state_e;

   localparam int DEF_NUM_SRC = 8;
   localparam int DEF_IDX_W   = 4;

   // mcause = CAUSE_INT_BIT | (CAUSE_EXT_BASE + int_index)
   localparam logic [31:0] CAUSE_INT_BIT  = 32'h8000_0000;
   localparam logic [31:0] CAUSE_EXT_BASE = 32'd16;

endpackage

// File: rtl/irq_sync.sv
// Per-source synchroniser; emits a rise pulse (edge source)
// or the synchronised level (level source).
module irq_sync #(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE        = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic src_i,
   output logic out_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], src_i};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
   end

   if (EDGE) begin : g_edge
      logic dly_q;
      logic dly_d;

      always_comb begin
         dly_d = sync_q[SYNC_STAGES-1];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) dly_q <= 1'b0;
         else     dly_q <= dly_d;
      end

      assign out_o = sync_q[SYNC_STAGES-1] & ~dly_q;
   end else begin : g_level
      assign out_o = sync_q[SYNC_STAGES-1];
   end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt controller: synchronise, latch, fixed-priority arbitrate,
// and drive trap entry/exit pulses towards IF and the CSR file.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int                 NUM_SRC     = DEF_NUM_SRC,
   parameter int                 IDX_W       = DEF_IDX_W,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [NUM_SRC-1:0] EDGE_MASK   = {NUM_SRC{1'b1}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [NUM_SRC-1:0] irq_enable,
   input  logic               int_mstatus_mie,
   input  logic               core_ready,
   input  logic               mret_en,
   output logic               trap_entry_en,
   output logic               trap_exit_en,
   output logic [IDX_W-1:0]   int_index,
   output logic               int_active,
   output logic [NUM_SRC-1:0] irq_pending
);

   irq_state_e         state_q, state_d;
   logic               entry_q, entry_d;
   logic               exit_q, exit_d;
   logic [IDX_W-1:0]   index_q, index_d;
   logic               active_q, active_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;

   logic [NUM_SRC-1:0] sync_out;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] win_oh;
   logic [IDX_W-1:0]   win_idx;
   logic               go;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      irq_sync #(
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE        (EDGE_MASK[i])
      ) u_sync (
         .clk   (clk),
         .rst   (rst),
         .src_i (irq_src[i]),
         .out_o (sync_out[i])
      );
   end

   // Edge bits come from the latch, level bits straight from the synchroniser.
   assign pend = (pend_q & EDGE_MASK) | (sync_out & ~EDGE_MASK);
   assign req  = pend & irq_enable;
   assign win_oh = req & (~req + NUM_SRC'(1));

   always_comb begin
      win_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) win_idx = IDX_W'(i);
      end
   end

   assign go = (state_q == IDLE) & int_mstatus_mie & (|req) & core_ready;

   // Set wins over the entry-cycle clear.
   always_comb begin
      pend_d = ((pend_q & ~(go ? win_oh : '0)) | sync_out) & EDGE_MASK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (go) state_d = ACTIVE;
         ACTIVE:  if (mret_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      entry_d  = go;
      exit_d   = (state_q == ACTIVE) & mret_en;
      index_d  = go ? win_idx : index_q;
      active_d = (state_d == ACTIVE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q  <= 1'b0;
         exit_q   <= 1'b0;
         index_q  <= '0;
         active_q <= 1'b0;
         pend_q   <= '0;
      end else begin
         entry_q  <= entry_d;
         exit_q   <= exit_d;
         index_q  <= index_d;
         active_q <= active_d;
         pend_q   <= pend_d;
      end
   end

   assign trap_entry_en = entry_q;
   assign trap_exit_en  = exit_q;
   assign int_index     = index_q;
   assign int_active    = active_q;
   assign irq_pending   = pend;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter; source 4 is level, others edge.
module tb_irq_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] irq_src;
   logic [7:0] irq_enable;
   logic       mie;
   logic       core_ready;
   logic       mret_en;
   logic       trap_entry_en;
   logic       trap_exit_en;
   logic [3:0] int_index;
   logic       int_active;
   logic [7:0] irq_pending;

   int total = 0;
   int bad   = 0;
   logic seen;

   irq_arbiter #(
      .NUM_SRC     (8),
      .IDX_W       (4),
      .SYNC_STAGES (2),
      .EDGE_MASK   (8'hEF)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .irq_src         (irq_src),
      .irq_enable      (irq_enable),
      .int_mstatus_mie (mie),
      .core_ready      (core_ready),
      .mret_en         (mret_en),
      .trap_entry_en   (trap_entry_en),
      .trap_exit_en    (trap_exit_en),
      .int_index       (int_index),
      .int_active      (int_active),
      .irq_pending     (irq_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic en, input logic ex,
                          input logic [3:0] idx, input logic act, input logic [7:0] pnd);
      chk({tag, ".entry"}, 32'(trap_entry_en), 32'(en));
      chk({tag, ".exit"}, 32'(trap_exit_en), 32'(ex));
      chk({tag, ".index"}, 32'(int_index), 32'(idx));
      chk({tag, ".active"}, 32'(int_active), 32'(act));
      chk({tag, ".pending"}, 32'(irq_pending), 32'(pnd));
   endtask

   task automatic pulse(input logic [7:0] bits);
      irq_src = bits;
      tick(1);
      irq_src = 8'h00;
   endtask

   task automatic do_mret();
      mret_en = 1'b1;
      tick(1);
      mret_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      irq_src = 8'h00;
      irq_enable = 8'h00;
      mie = 1'b1;
      core_ready = 1'b1;
      mret_en = 1'b0;
      tick(3);
      chk_out("reset", 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      rst = 1'b0;
      tick(2);

      // single edge source 3
      irq_enable = 8'h08;
      pulse(8'h08);
      tick(2);
      chk_out("t1.c3", 1'b0, 1'b0, 4'd0, 1'b0, 8'h08);
      tick(1);
      chk_out("t1.c4", 1'b1, 1'b0, 4'd3, 1'b1, 8'h00);
      tick(1);
      chk_out("t1.c5", 1'b0, 1'b0, 4'd3, 1'b1, 8'h00);
      do_mret();
      chk_out("t1.exit", 1'b0, 1'b1, 4'd3, 1'b0, 8'h00);
      tick(1);
      chk_out("t1.idle", 1'b0, 1'b0, 4'd3, 1'b0, 8'h00);

      // simultaneous 5 and 2
      irq_enable = 8'hFF;
      pulse(8'h24);
      tick(3);
      chk_out("t2.e1", 1'b1, 1'b0, 4'd2, 1'b1, 8'h20);
      tick(1);
      do_mret();
      chk_out("t2.x1", 1'b0, 1'b1, 4'd2, 1'b0, 8'h20);
      tick(1);
      chk_out("t2.e2", 1'b1, 1'b0, 4'd5, 1'b1, 8'h00);
      do_mret();
      chk_out("t2.x2", 1'b0, 1'b1, 4'd5, 1'b0, 8'h00);
      tick(1);

      // mie gating
      mie = 1'b0;
      pulse(8'h02);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         seen = seen | trap_entry_en | int_active;
      end
      chk("t3.noentry", 32'(seen), 32'd0);
      chk("t3.pend", 32'(irq_pending), 32'h02);
      mie = 1'b1;
      tick(1);
      chk_out("t3.entry", 1'b1, 1'b0, 4'd1, 1'b1, 8'h00);
      do_mret();
      chk("t3.exit", 32'(trap_exit_en), 32'd1);
      tick(1);

      // core_ready stall
      core_ready = 1'b0;
      pulse(8'h01);
      tick(2);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         seen = seen | trap_entry_en;
      end
      chk("t4.noentry", 32'(seen), 32'd0);
      chk("t4.pend", 32'(irq_pending), 32'h01);
      core_ready = 1'b1;
      tick(1);
      chk_out("t4.entry", 1'b1, 1'b0, 4'd0, 1'b1, 8'h00);
      do_mret();
      chk("t4.exit", 32'(trap_exit_en), 32'd1);
      tick(1);

      // level source 4 held through service
      irq_src = 8'h10;
      tick(2);
      chk_out("t5.c2", 1'b0, 1'b0, 4'd0, 1'b0, 8'h10);
      tick(1);
      chk_out("t5.e1", 1'b1, 1'b0, 4'd4, 1'b1, 8'h10);
      tick(1);
      do_mret();
      chk_out("t5.x1", 1'b0, 1'b1, 4'd4, 1'b0, 8'h10);
      tick(1);
      chk_out("t5.e2", 1'b1, 1'b0, 4'd4, 1'b1, 8'h10);
      irq_src = 8'h00;
      tick(3);
      chk("t5.dropped", 32'(irq_pending), 32'h00);
      do_mret();
      tick(1);
      chk_out("t5.noreent", 1'b0, 1'b0, 4'd4, 1'b0, 8'h00);

      // level drop before entry
      core_ready = 1'b0;
      irq_src = 8'h10;
      tick(2);
      chk("t5b.pend", 32'(irq_pending), 32'h10);
      irq_src = 8'h00;
      tick(2);
      chk("t5b.clear", 32'(irq_pending), 32'h00);
      core_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         seen = seen | trap_entry_en;
      end
      chk("t5b.notrap", 32'(seen), 32'd0);

      // reset during ACTIVE with source 6 pending
      pulse(8'h48);
      tick(3);
      chk_out("t6.active", 1'b1, 1'b0, 4'd3, 1'b1, 8'h40);
      #2;
      rst = 1'b1;
      #1;
      chk_out("t6.rst", 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      tick(1);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         seen = seen | trap_entry_en | int_active;
      end
      chk("t6.noentry", 32'(seen), 32'd0);
      chk("t6.pend", 32'(irq_pending), 32'h00);
      do_mret();
      chk("t6.mret_idle", 32'(trap_exit_en), 32'd0);
      pulse(8'h40);
      tick(3);
      chk_out("t6.new", 1'b1, 1'b0, 4'd6, 1'b1, 8'h00);
      do_mret();
      chk("t6.exit", 32'(trap_exit_en), 32'd1);
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
